// File: rtl/btb_pkg.sv
// btb_pkg: shared types for the set-associative branch target buffer.
package btb_pkg;
    typedef enum logic [1:0] {BR = 2'd0, JMP = 2'd1, CALL = 2'd2, RET = 2'd3} btype_e;
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;
    // Widest target an entry can hold; S_TARGET must not exceed it.
    localparam int TARGET_W = 30;
    typedef struct packed {
        logic [TARGET_W-1:0] target;
        btype_e              btype;
    } entry_t;
endpackage

// File: rtl/btb_set_assoc_if.sv
// btb_set_assoc_if: lookup, update and flush signals of the BTB.
interface btb_set_assoc_if
    import btb_pkg::*;
#(
    parameter int S_PC     = 29,
    parameter int S_TARGET = 30
);
    logic                lk_valid;
    logic [S_PC-1:0]     lk_pc;
    logic                lk_rvalid;
    logic                lk_hit;
    logic [S_TARGET-1:0] lk_target;
    btype_e              lk_btype;
    logic                upd_valid;
    logic                upd_ready;
    logic [S_PC-1:0]     upd_pc;
    logic [S_TARGET-1:0] upd_target;
    btype_e              upd_btype;
    logic                flush;
    logic                flush_busy;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_btype, flush,
        input  lk_rvalid, lk_hit, lk_target, lk_btype, upd_ready, flush_busy
    );
    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_btype, flush,
        output lk_rvalid, lk_hit, lk_target, lk_btype, upd_ready, flush_busy
    );
endinterface

// File: rtl/btb_plru_tree.sv
// btb_plru_tree: tree-PLRU victim pick and touch update for one set.
module btb_plru_tree #(
    parameter int N_WAYS = 4,
    localparam int WB = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-2:0] bits,
    input  logic [WB-1:0]     way,
    output logic [WB-1:0]     victim,
    output logic [N_WAYS-2:0] next
);
    logic [WB-1:0] vn, tn;

    // Nodes are heap-ordered: children of node n are 2n+1 (lower) and 2n+2 (upper).
    always_comb begin
        victim = '0;
        vn = '0;
        for (int l = 0; l < WB; l++) begin
            victim[WB-1-l] = bits[vn];
            vn = WB'(2 * int'(vn) + 1 + int'(bits[vn]));
        end
    end

    always_comb begin
        next = bits;
        tn = '0;
        for (int l = 0; l < WB; l++) begin
            next[tn] = ~way[WB-1-l];
            tn = WB'(2 * int'(tn) + 1 + int'(way[WB-1-l]));
        end
    end
endmodule

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: N_WAYS-way set-associative branch target buffer with
// tree-PLRU replacement and a one-set-per-cycle flush walker.
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int N_SETS   = 16,
    parameter int N_WAYS   = 4,
    parameter int S_PC     = 29,
    parameter int S_TARGET = 30
) (
    input logic            clk,
    input logic            rst,
    btb_set_assoc_if.slave bus
);
    localparam int IB = $clog2(N_SETS);
    localparam int WB = $clog2(N_WAYS);
    localparam int TW = S_PC - IB;

    state_e state, state_next;
    logic [IB-1:0] cnt, cnt_next;
    logic busy, upd_go, lk_hit_c;

    logic [TW-1:0] tags [N_SETS][N_WAYS];
    entry_t        data [N_SETS][N_WAYS];
    logic [N_SETS-1:0][N_WAYS-1:0] valid;
    logic [N_SETS-1:0][N_WAYS-2:0] plru, plru_next;
    logic [N_SETS-1:0][WB-1:0]     victims, touch_way;
    logic [N_SETS-1:0]             touch;

    logic [IB-1:0]     lk_set, up_set;
    logic [TW-1:0]     lk_tag, up_tag;
    logic [N_WAYS-1:0] lk_match, up_match;
    logic [WB-1:0]     lk_way, up_hit_way, free_way, up_way;

    logic                rvalid_q, hit_q;
    logic [S_TARGET-1:0] target_q;
    btype_e              btype_q;

    assign lk_set = bus.lk_pc[IB-1:0];
    assign lk_tag = bus.lk_pc[S_PC-1:IB];
    assign up_set = bus.upd_pc[IB-1:0];
    assign up_tag = bus.upd_pc[S_PC-1:IB];

    assign busy     = state == FLUSH;
    assign upd_go   = bus.upd_valid && !busy && !bus.flush;
    assign lk_hit_c = bus.lk_valid && !busy && |lk_match;

    assign bus.upd_ready  = !busy;
    assign bus.flush_busy = busy;
    assign bus.lk_rvalid  = rvalid_q;
    assign bus.lk_hit     = hit_q;
    assign bus.lk_target  = target_q;
    assign bus.lk_btype   = btype_q;

    always_comb begin
        for (int w = 0; w < N_WAYS; w++) begin
            lk_match[w] = valid[lk_set][w] && tags[lk_set][w] == lk_tag;
            up_match[w] = valid[up_set][w] && tags[up_set][w] == up_tag;
        end
    end

    // Downward scans leave the lowest matching / lowest invalid way selected.
    always_comb begin
        lk_way = '0;
        up_hit_way = '0;
        free_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            lk_way = lk_match[w] ? WB'(w) : lk_way;
            up_hit_way = up_match[w] ? WB'(w) : up_hit_way;
            free_way = !valid[up_set][w] ? WB'(w) : free_way;
        end
        up_way = |up_match ? up_hit_way : (&valid[up_set] ? victims[up_set] : free_way);
    end

    // When both touch the same set the update's way is used, so it wins.
    always_comb begin
        for (int s = 0; s < N_SETS; s++) begin
            touch[s] = (upd_go && up_set == IB'(s)) || (lk_hit_c && lk_set == IB'(s));
            touch_way[s] = (upd_go && up_set == IB'(s)) ? up_way : lk_way;
        end
    end

    for (genvar s = 0; s < N_SETS; s++) begin : g_set
        btb_plru_tree #(.N_WAYS(N_WAYS)) u_plru (
            .bits  (plru[s]),
            .way   (touch_way[s]),
            .victim(victims[s]),
            .next  (plru_next[s])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state == IDLE ? (bus.flush ? FLUSH : IDLE)
                                   : (cnt == IB'(N_SETS - 1) ? IDLE : FLUSH);
        cnt_next = state == IDLE ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            plru <= '0;
            rvalid_q <= 1'b0;
            hit_q <= 1'b0;
            target_q <= '0;
            btype_q <= BR;
        end else begin
            rvalid_q <= bus.lk_valid;
            hit_q <= lk_hit_c;
            target_q <= lk_hit_c ? S_TARGET'(data[lk_set][lk_way].target) : '0;
            btype_q <= lk_hit_c ? data[lk_set][lk_way].btype : BR;
            for (int s = 0; s < N_SETS; s++) begin
                if (busy && cnt == IB'(s)) begin
                    valid[s] <= '0;
                    plru[s] <= '0;
                end else if (touch[s]) begin
                    plru[s] <= plru_next[s];
                end
            end
            if (upd_go) valid[up_set][up_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_go) begin
            tags[up_set][up_way] <= up_tag;
            data[up_set][up_way] <= '{target: TARGET_W'(bus.upd_target), btype: bus.upd_btype};
        end
    end
endmodule

// File: tb/tb_btb_set_assoc.sv
// tb_btb_set_assoc: directed and randomized checks of btb_set_assoc against a behavioural model.
module tb_btb_set_assoc;
    import btb_pkg::*;
    localparam int NS = 4, NW = 4, LV = 2, SPC = 29, STG = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_set_assoc_if #(.S_PC(SPC), .S_TARGET(STG)) bus ();
    btb_set_assoc #(.N_SETS(NS), .N_WAYS(NW), .S_PC(SPC), .S_TARGET(STG)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    bit e_rv, e_hit, e_busy;
    logic [29:0] e_tgt;
    logic [1:0] e_bt;

    // Model: ways per set, and PLRU nodes addressed by (level, way prefix).
    bit mv [NS][NW];
    int mtag [NS][NW];
    logic [29:0] mtgt [NS][NW];
    logic [1:0] mbt [NS][NW];
    bit pl [NS][LV][NW];
    bit mbusy;
    int mcnt;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
        end
    endtask

    task automatic m_touch(int s, int w);
        for (int l = 0; l < LV; l++) pl[s][l][w >> (LV - l)] = ((w >> (LV - 1 - l)) & 1) == 0;
    endtask

    function automatic int m_victim(int s);
        int w = 0;
        for (int l = 0; l < LV; l++) w = 2 * w + int'(pl[s][l][w]);
        return w;
    endfunction

    task automatic m_clear_set(int s);
        for (int w = 0; w < NW; w++) mv[s][w] = 0;
        for (int l = 0; l < LV; l++)
            for (int k = 0; k < NW; k++) pl[s][l][k] = 0;
    endtask

    task automatic model_step(bit lkv, int lkpc, bit uv, int upc, int ut, int ub, bit fl);
        int ls = -1, lw = -1, us = -1, uw = -1, s;
        chk_en = 1;
        if (rst) begin
            for (int i = 0; i < NS; i++) m_clear_set(i);
            mbusy = 0; mcnt = 0;
            e_rv = 0; e_hit = 0; e_tgt = 0; e_bt = 0; e_busy = 0;
            return;
        end
        e_rv = lkv; e_hit = 0; e_tgt = 0; e_bt = 0;
        if (lkv && !mbusy) begin
            s = lkpc % NS;
            for (int w = 0; w < NW; w++) if (lw < 0 && mv[s][w] && mtag[s][w] == lkpc / NS) lw = w;
            if (lw >= 0) begin
                ls = s; e_hit = 1; e_tgt = mtgt[s][lw]; e_bt = mbt[s][lw];
            end
        end
        if (uv && !mbusy && !fl) begin
            us = upc % NS;
            for (int w = 0; w < NW; w++) if (uw < 0 && mv[us][w] && mtag[us][w] == upc / NS) uw = w;
            for (int w = 0; w < NW; w++) if (uw < 0 && !mv[us][w]) uw = w;
            if (uw < 0) uw = m_victim(us);
            mv[us][uw] = 1; mtag[us][uw] = upc / NS; mtgt[us][uw] = 30'(ut); mbt[us][uw] = 2'(ub);
        end
        if (ls >= 0 && ls != us) m_touch(ls, lw);
        if (us >= 0) m_touch(us, uw);
        if (mbusy) begin
            m_clear_set(mcnt);
            mcnt++;
            if (mcnt == NS) mbusy = 0;
        end else if (fl) begin
            mbusy = 1; mcnt = 0;
        end
        e_busy = mbusy;
    endtask

    task automatic step(bit lkv, int lkpc, bit uv, int upc, int ut, int ub, bit fl);
        @(negedge clk);
        bus.lk_valid = lkv;
        bus.lk_pc = SPC'(lkpc);
        bus.upd_valid = uv;
        bus.upd_pc = SPC'(upc);
        bus.upd_target = STG'(ut);
        bus.upd_btype = btype_e'(2'(ub));
        bus.flush = fl;
        model_step(lkv, lkpc, uv, upc, ut, ub, fl);
        @(posedge clk);
        #3;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lk(int pc); step(1, pc, 0, 0, 0, 0, 0); endtask
    task automatic up(int pc, int t, int b); step(0, 0, 1, pc, t, b, 0); endtask

    task automatic do_reset();
        rst = 1; idle(); idle(); rst = 0;
    endtask

    task automatic fill_set0();
        up(0, 'hA0, 0); up(4, 'hA4, 1); up(8, 'hA8, 2); up(12, 'hAC, 3);
    endtask

    task automatic lit(string name, bit h, int t);
        chk({name, " rvalid"}, 32'(bus.lk_rvalid), 32'd1);
        chk({name, " hit"}, 32'(bus.lk_hit), 32'(h));
        chk({name, " target"}, 32'(bus.lk_target), 32'(t));
        chk({name, " model hit"}, 32'(e_hit), 32'(h));
        chk({name, " model target"}, 32'(e_tgt), 32'(t));
    endtask

    task automatic flush_state(string name, bit b);
        chk({name, " flush_busy"}, 32'(bus.flush_busy), 32'(b));
        chk({name, " upd_ready"}, 32'(bus.upd_ready), 32'(!b));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                chk("cmp lk_rvalid", 32'(bus.lk_rvalid), 32'(e_rv));
                chk("cmp lk_hit", 32'(bus.lk_hit), 32'(e_hit));
                chk("cmp lk_target", 32'(bus.lk_target), 32'(e_tgt));
                chk("cmp lk_btype", 32'(bus.lk_btype), 32'(e_bt));
                chk("cmp flush_busy", 32'(bus.flush_busy), 32'(e_busy));
                chk("cmp upd_ready", 32'(bus.upd_ready), 32'(!e_busy));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lk_valid = 0; bus.lk_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0;
        bus.upd_target = '0; bus.upd_btype = BR; bus.flush = 0;

        do_reset();
        chk("reset rvalid", 32'(bus.lk_rvalid), 32'd0);
        flush_state("reset", 0);
        lk('h10); lit("cold miss", 0, 0);
        up('h10, 'h100, 0); lk('h10); lit("hit after update", 1, 'h100);
        step(1, 'h10, 1, 'h10, 'h300, 1, 0); lit("read before write", 1, 'h100);
        lk('h10); lit("new value", 1, 'h300);
        chk("new btype", 32'(bus.lk_btype), 32'(JMP));

        do_reset();
        fill_set0();
        lk('h00); lit("fill hit 0x00", 1, 'hA0);
        up('h10, 'hB0, 2);
        lk('h08); lit("evicted 0x08", 0, 0);
        lk('h00); lit("kept 0x00", 1, 'hA0);
        lk('h04); lit("kept 0x04", 1, 'hA4);
        lk('h0C); lit("kept 0x0C", 1, 'hAC);
        lk('h10); lit("new 0x10", 1, 'hB0);

        do_reset();
        fill_set0();
        up('h04, 'h200, 3);
        lk('h04); lit("rewrite 0x04", 1, 'h200);
        lk('h00); lit("still 0x00", 1, 'hA0);
        lk('h08); lit("still 0x08", 1, 'hA8);
        lk('h0C); lit("still 0x0C", 1, 'hAC);

        do_reset();
        for (int p = 0; p < 16; p++) up(p, 'hC00 + p, p % 4);
        lk(5); lit("filled 0x05", 1, 'hC05);
        step(0, 0, 1, 20, 1, 0, 1); flush_state("flush c1", 1);
        step(0, 0, 1, 21, 2, 0, 1); flush_state("flush c2", 1);
        lk(3); flush_state("flush c3", 1); lit("lookup in flush", 0, 0);
        idle(); flush_state("flush c4", 1);
        idle(); flush_state("flush done", 0);
        for (int p = 0; p < 16; p++) begin
            lk(p); lit("after flush", 0, 0);
        end
        lk(20); lit("update during flush", 0, 0);

        do_reset();
        up('h07, 'h11, 0); up('h07, 'h22, 1); lk('h07); lit("back to back update", 1, 'h22);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 399) == 0;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 32'h3FFF_FFFF)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 59) == 0);
        end
        rst = 0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
